aibnd_red_shift_ctrl: RTL
=========================

# aibnd_red_shift_ctrl

Sequencer for the AIB IO redundancy shift chain. Accepts a repair configuration (repair enable plus failing-IO index) over a valid/ready handshake, converts it into the per-IO thermometer `shift_en` vector, and owns the shared analog reset. The analog reset is held low while the shift pattern changes and is released only after a programmable settle window. The block sits between the configuration/CSR logic and the array of per-IO redundancy cells, whose `shift_en`/`prev_io_shift_en`/`anlg_rstb` inputs it drives.

## Interface

Parameters:
- `NIO`, 24: number of IO cells in the chain; must be ≥ 2.
- `IDXW`, 5: width of the IO index; 2^IDXW ≥ NIO.
- `QUIESCE_CYC`, 4: cycles the analog reset is held low before the shift pattern changes; must be ≥ 1.
- `SETTLE_CYC`, 8: cycles after the shift pattern changes before release; must be ≥ 1.
- `CNTW`, 8: width of the shared wait counter; must hold max(QUIESCE_CYC, SETTLE_CYC).

Ports:
- `clk`, in, 1: block clock.
- `rstb`, in, 1: reset. Asynchronous assertion and active-low, as already decided for this block. Synchronous deassertion is handled upstream.
- `cfg_valid`, in, 1: configuration request.
- `cfg_ready`, out, 1: block can accept a configuration.
- `cfg_en`, in, 1: 1 = repair active, 0 = no repair.
- `cfg_idx`, in, IDXW: index of the failing IO; ignored when `cfg_en`=0.
- `cfg_err`, out, 1: one-cycle pulse when an illegal configuration is rejected.
- `anlg_rstb_req`, in, 1: upstream request to release the analog reset.
- `anlg_rstb_out`, out, 1: analog reset to the redundancy cells, active-low.
- `shift_en`, out, NIO: per-IO shift enable. Bit i is also routed as `prev_io_shift_en` of IO i+1.
- `busy`, out, 1: a reconfiguration sequence is in progress.
- `done`, out, 1: one-cycle pulse when a sequence completes.
- `cur_en`, out, 1: currently applied repair enable.
- `cur_idx`, out, IDXW: currently applied index.

## Operation

Reset (`rstb`=0, at any time including mid-sequence):
- State returns to IDLE and the counter clears.
- `shift_en`=0, `cur_en`=0, `cur_idx`=0.
- `anlg_rstb_out`=0, `cfg_ready`=0, `cfg_err`=0, `busy`=0, `done`=0.
- `cfg_ready` rises in the first clock edge after `rstb` deasserts.

States:
- **IDLE**
  - `cfg_ready`=1.
  - Handshake occurs on `cfg_valid`&`cfg_ready`.
  - If `cfg_en`=1 and `cfg_idx`≥NIO: the request is consumed, `cfg_err` pulses on the next cycle, and the state stays IDLE with no output change.
  - Otherwise the request is latched and the state goes to QUIESCE.
- **QUIESCE**: held for QUIESCE_CYC cycles, then goes to APPLY.
- **APPLY**
  - Lasts one cycle.
  - Registers `shift_en[i] = cfg_en & (i ≥ idx)` (thermometer; all zero when `cfg_en`=0).
  - Updates `cur_en` and `cur_idx`.
  - Goes to SETTLE.
- **SETTLE**: held for SETTLE_CYC cycles, then goes to DONE.
- **DONE**: lasts one cycle, pulses `done`, then returns to IDLE.

Status outputs:
- `busy`=1 in QUIESCE, APPLY, SETTLE and DONE.
- `cfg_ready`=0 whenever `busy`=1.

Analog reset:
- Internal flag `rel_q` is cleared on entry to QUIESCE and stays 0 through APPLY and SETTLE.
- In DONE and IDLE, `rel_q` takes the registered value of `anlg_rstb_req`.
- `anlg_rstb_out = rel_q & anlg_rstb_req`. Deasserting `anlg_rstb_req` drops the output combinationally in the same cycle, in every state.
- Release is registered: it never occurs before `shift_en` has been stable for SETTLE_CYC cycles.

Re-applying an identical configuration runs the full sequence; there is no shortcut.

## Timing

Handshake accepted at cycle 0, with Q=QUIESCE_CYC and S=SETTLE_CYC:
- Cycle 1: state QUIESCE, `busy`=1, `cfg_ready`=0, `anlg_rstb_out`=0.
- Cycles 1..Q: QUIESCE. Old `shift_en` is held.
- Cycle Q+1: APPLY.
- Cycle Q+2: new `shift_en`, `cur_en` and `cur_idx` are visible.
- Cycles Q+2..Q+S+1: SETTLE.
- Cycle Q+S+2: DONE. `done`=1, and `anlg_rstb_out`=1 if `anlg_rstb_req` was 1 in cycle Q+S+1 and is still 1.
- Cycle Q+S+3: IDLE, `cfg_ready`=1.
- With default parameters: `shift_en` changes at cycle 6, `done` at cycle 14, `cfg_ready` at cycle 15.

Other timing rules:
- The earliest next handshake is cycle Q+S+3; back-to-back configurations are spaced Q+S+3 cycles apart.
- Illegal index: `cfg_err` is 1 at cycle 1 only. `cfg_ready` stays 1, and a new request may be accepted at cycle 1.
- In IDLE, rising `anlg_rstb_req` appears on `anlg_rstb_out` one cycle later.

## Test plan

- **Reset and idle release:** reset, then `anlg_rstb_req`=1 → `shift_en`=0 and `anlg_rstb_out` rises 1 cycle after the request; `cfg_ready`=1.
- **Repair IO 5 (defaults):** `cfg_en`=1, `cfg_idx`=5 with `anlg_rstb_req`=1 held →
  - `anlg_rstb_out`=0 from cycle 1.
  - `shift_en`=24'hFFFFE0 at cycle 6.
  - `done` and `anlg_rstb_out`=1 at cycle 14.
  - `cfg_ready` at cycle 15.
- **Boundary indices:**
  - `cfg_idx`=0 → `shift_en`=24'hFFFFFF.
  - `cfg_idx`=23 → `shift_en`=24'h800000.
  - `cfg_en`=0 with `cfg_idx`=7 → `shift_en`=0.
- **Illegal index:** `cfg_idx`=24 with `cfg_en`=1 → `cfg_err` pulse at cycle 1; `shift_en`, `cur_idx` and `anlg_rstb_out` unchanged; `busy` stays 0.
- **Request drop:** `anlg_rstb_req` deasserted at cycle 10 of a sequence and reasserted at cycle 20 → `anlg_rstb_out` stays 0 through `done` at cycle 14 and rises at cycle 21.
- **Reset mid-sequence:** `rstb` pulsed low at cycle 8 → all outputs immediately take reset values; a subsequent configuration runs the full sequence normally.

Source files
------------

// File: rtl/aibnd_red_shift_ctrl.sv
// aibnd_red_shift_ctrl: sequencer for the AIB IO redundancy shift chain.
// It takes a repair configuration over valid/ready and turns it into the
// thermometer shift_en vector. While the pattern changes, the shared analog
// reset is held low. It is released only after a settle window.
module aibnd_red_shift_ctrl #(
  parameter int NIO         = 24,
  parameter int IDXW        = 5,
  parameter int QUIESCE_CYC = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int CNTW        = 8
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic            cfg_en,
  input  logic [IDXW-1:0] cfg_idx,
  output logic            cfg_err,
  input  logic            anlg_rstb_req,
  output logic            anlg_rstb_out,
  output logic [NIO-1:0]  shift_en,
  output logic            busy,
  output logic            done,
  output logic            cur_en,
  output logic [IDXW-1:0] cur_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_APPLY, S_SETTLE, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            req_en_q;
  logic [IDXW-1:0] req_idx_q;
  logic            rdy_q, err_q, rel_q;
  logic [NIO-1:0]  shift_q, therm;
  logic            cur_en_q;
  logic [IDXW-1:0] cur_idx_q;
  logic            hs, bad_idx, ld;

  // rdy_q is only ever set while IDLE, so the handshake needs no state check
  assign hs      = cfg_valid & rdy_q;
  assign bad_idx = cfg_en & (32'(cfg_idx) >= 32'(NIO));
  assign ld      = hs & ~bad_idx;

  // Thermometer: IO i shifts when it sits at or above the failing index
  for (genvar g = 0; g < NIO; g++) begin : g_therm
    assign therm[g] = req_en_q & (req_idx_q <= IDXW'(g));
  end

  // Next-state logic; one shared counter times both wait windows
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:    if (ld) state_d = S_QUIESCE;
      S_QUIESCE: begin
        if (cnt_q == CNTW'(QUIESCE_CYC - 1)) state_d = S_APPLY;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
      S_APPLY:   state_d = S_SETTLE;
      S_SETTLE: begin
        if (cnt_q == CNTW'(SETTLE_CYC - 1)) state_d = S_DONE;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State and wait counter
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture an accepted legal request; it is applied later, in APPLY
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      req_en_q  <= 1'b0;
      req_idx_q <= '0;
    end else if (ld) begin
      req_en_q  <= cfg_en;
      req_idx_q <= cfg_idx;
    end
  end

  // Drive the new shift pattern and the applied configuration in APPLY only
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      shift_q   <= '0;
      cur_en_q  <= 1'b0;
      cur_idx_q <= '0;
    end else if (state_q == S_APPLY) begin
      shift_q   <= therm;
      cur_en_q  <= req_en_q;
      cur_idx_q <= req_idx_q;
    end
  end

  // Ready, error pulse and the release flag. The release flag can only
  // follow the request once the sequence has reached DONE or IDLE.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      rdy_q <= (state_d == S_IDLE);
      err_q <= hs & bad_idx;
      rel_q <= ((state_d == S_IDLE) || (state_d == S_DONE)) & anlg_rstb_req;
    end
  end

  assign cfg_ready     = rdy_q;
  assign cfg_err       = err_q;
  assign anlg_rstb_out = rel_q & anlg_rstb_req;
  assign shift_en      = shift_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign cur_en        = cur_en_q;
  assign cur_idx       = cur_idx_q;

endmodule
